// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch controller.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0) presented while nothing was fetched
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // A PC is fetchable when word aligned and inside the memory window
  function automatic logic pc_legal(input logic [PC_W-1:0] pc, input int unsigned depth);
    return (pc[1:0] == 2'b00) && ({2'b00, pc[PC_W-1:2]} < depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_perf_cnt.sv
// -----------------------------------------------------------------------------
// fetch_perf_cnt
// Saturating counters for accepted fetches and discarded (flushed) fetches.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_accept,
  input  logic        i_flush,
  output logic [31:0] o_fetch_cnt,
  output logic [15:0] o_flush_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  // Count events, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_accept && !(&r_fetch_cnt)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_flush  && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Fixed-latency instruction fetch controller with redirect and fault handling.
// Optional feature macro: FETCH_PERF_CNT_EN (enables perf counters).
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_LAT   = 2,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
  output logic [31:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt
);

  localparam logic [3:0] LAT_CNT = 4'(IMEM_LAT);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [3:0]   r_cnt;
  logic         r_if_valid;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_instr;
  logic         r_fault;

  logic         w_handshake;
  logic         w_enter;
  logic [31:0]  w_target;
  logic         w_target_ok;
  logic [3:0]   w_cnt_dec;

  assign w_handshake = (r_state == ST_VALID) && if_ready;
  assign w_cnt_dec   = r_cnt - 4'd1;
  assign w_target_ok = pc_legal(w_target, IMEM_DEPTH);

  // Decide whether a new fetch starts this cycle and from which address
  always_comb begin
    w_enter  = 1'b0;
    w_target = r_pc;
    case (r_state)
      ST_IDLE: begin
        w_enter  = 1'b1;
        w_target = RESET_PC;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          w_enter  = 1'b1;
          w_target = redirect_pc;
        end
      end
      ST_VALID: begin
        // Redirect outranks the sequential next-PC even when the handshake completes
        if (redirect_valid) begin
          w_enter  = 1'b1;
          w_target = redirect_pc;
        end else if (if_ready) begin
          w_enter  = 1'b1;
          w_target = r_pc + 32'd4;
        end
      end
      ST_FAULT: begin
        if (redirect_valid && pc_legal(redirect_pc, IMEM_DEPTH)) begin
          w_enter  = 1'b1;
          w_target = redirect_pc;
        end
      end
      default: ;
    endcase
  end

  // Fetch state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_cnt      <= '0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= NOP_INSTR;
      r_fault    <= 1'b0;
    end else if (w_enter) begin
      r_pc       <= w_target;
      r_if_valid <= 1'b0;
      if (w_target_ok) begin
        r_state <= ST_FETCH;
        r_cnt   <= LAT_CNT;
        r_fault <= 1'b0;
      end else begin
        r_state <= ST_FAULT;
        r_fault <= 1'b1;
      end
    end else if (r_state == ST_FETCH) begin
      r_cnt <= w_cnt_dec;
      if (w_cnt_dec == 4'd0) begin
        r_if_instr <= imem_rdata;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b1;
        r_state    <= ST_VALID;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_instr    = r_if_instr;
  assign fetch_fault = r_fault;

`ifdef FETCH_PERF_CNT_EN
  logic w_flush;

  // A redirect flushes an in-flight fetch or an instruction nobody accepted
  assign w_flush = redirect_valid &&
                   ((r_state == ST_FETCH) || ((r_state == ST_VALID) && !if_ready));

  fetch_perf_cnt u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_accept    (w_handshake),
    .i_flush     (w_flush),
    .o_fetch_cnt (perf_fetch_cnt),
    .o_flush_cnt (perf_flush_cnt)
  );
`else
  logic w_unused_hs;
  assign w_unused_hs    = w_handshake;
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter IMEM_LAT, default 2, cycles from address issue to valid instruction data (legal range 1..15).
REQ-003 SHALL have parameter IMEM_DEPTH, default 256, instruction memory depth in words.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_addr  out  32  byte address to instruction memory.
REQ-007 SHALL have port imem_rdata  in  32  instruction word from memory.
REQ-008 SHALL have port redirect_valid  in  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  in  32  redirect target byte address.
REQ-010 SHALL have port if_ready  in  1  IF/ID stage accepts the presented instruction.
REQ-011 SHALL have port if_valid  out  1  if_instr/if_pc are valid.
REQ-012 SHALL have port if_pc  out  32  PC of the presented instruction.
REQ-013 SHALL have port if_instr  out  32  presented instruction.
REQ-014 SHALL have port fetch_fault  out  1  sticky misaligned/out-of-range PC flag.
REQ-015 SHALL have port perf_fetch_cnt  out  32  accepted-instruction count.
REQ-016 SHALL have port perf_flush_cnt  out  16  discarded-fetch count.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, VALID, FAULT.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then enter FETCH with pc=RESET_PC.
REQ-019 On entering FETCH, wait counter SHALL load IMEM_LAT; imem_addr SHALL equal pc throughout FETCH and VALID.
REQ-020 FETCH SHALL decrement the counter each cycle; on the cycle counter reaches 0, imem_rdata SHALL be registered into if_instr, pc into if_pc, if_valid set, state VALID.
REQ-021 if_valid SHALL rise exactly IMEM_LAT cycles after the first FETCH cycle.
REQ-022 In VALID, if_instr/if_pc/if_valid SHALL hold stable while if_ready=0.
REQ-023 In VALID with if_ready=1: handshake completes, pc <= pc+4, if_valid cleared next cycle, state FETCH; sustained throughput one instruction per IMEM_LAT+1 cycles.
REQ-024 redirect_valid SHALL have priority in FETCH and VALID: pc <= redirect_pc, if_valid <= 0, counter reloaded, state FETCH; in-flight or unaccepted instruction is discarded.
REQ-025 Redirect simultaneous with a VALID handshake: the handshake counts as accepted, then redirect applies; pc+4 is not used.
REQ-026 pc[1:0]!=0 or (pc>>2)>=IMEM_DEPTH on entering FETCH SHALL go to FAULT instead: fetch_fault=1, if_valid=0.
REQ-027 FAULT SHALL exit only on redirect_valid with a legal redirect_pc (to FETCH, fetch_fault cleared) or on reset; illegal redirect stays in FAULT.
REQ-028 pc+4 arithmetic SHALL be 32-bit modulo; wrap is caught by REQ-026.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, pc=RESET_PC, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), fetch_fault=0, both perf counters 0.
REQ-030 Reset asserted mid-FETCH or mid-VALID SHALL discard the instruction with no handshake.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: perf_fetch_cnt increments per accepted handshake, perf_flush_cnt per redirect that discards a FETCH/VALID instruction; both saturate at all-ones.
REQ-032 FETCH_PERF_CNT_EN undefined: counter logic absent, both ports tied to 0, ports retained.

Structure
REQ-033 Package fetch_pkg SHALL hold the state enum, PC/instruction width constants, NOP constant 32'h0000_0013.
REQ-034 Perf counters SHALL live in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-035 Reset release, if_ready=1, IMEM_LAT=2 -> if_pc 0x0,0x4,0x8 presented, valid every 3 cycles, if_instr matches memory words.
REQ-036 if_ready=0 for 5 cycles while VALID at pc 0x8 -> if_pc/if_instr stable, imem_addr stays 0x8, no pc advance.
REQ-037 redirect_valid with redirect_pc=0x28 during FETCH of 0x10 -> 0x10 never valid, next if_pc=0x28, perf_flush_cnt=1 (macro on).
REQ-038 redirect_pc=0x2A, then 0x400 (IMEM_DEPTH=256) -> fetch_fault=1, if_valid=0; redirect 0x0 -> fault clears, if_pc=0x0.
REQ-039 rst_n low mid-FETCH -> immediate IDLE, if_valid=0, if_instr=0x13, counters 0; macro off -> perf ports read 0 throughout.
